// File: rtl/target_bbox_tracker.sv
// ---------------------------------------------------------------------------
// target_bbox_tracker
//   Accumulates, per frame, the bounding box and pixel count of the moving
//   pixels in a binary mask stream. The result is published at each vsync
//   rising edge. The video stream is re-emitted one cycle later, with the last
//   published box drawn as a one-pixel coloured border.
//
// Ports
//   clk, rst                   pixel clock, synchronous active-high reset
//   per_frame_vsync/href/clken incoming frame sync, line valid, pixel strobe
//   per_img_bit                1 = moving pixel
//   per_img_data               RGB565 pixel to pass through
//   post_frame_vsync/href/clken  sync signals delayed by one cycle
//   post_img_data              pixel with the box overlay applied
//   target_valid               published box holds at least MIN_PIXELS hits
//   box_xmin/xmax/ymin/ymax    published box edges
//   hit_count                  moving-pixel count of the last completed frame
//   frame_done                 one-cycle pulse when results are published
// ---------------------------------------------------------------------------
module target_bbox_tracker #(
    parameter int          IMG_HDISP  = 640,
    parameter int          IMG_VDISP  = 480,
    parameter int          MIN_PIXELS = 64,
    parameter logic [15:0] BOX_COLOR  = 16'hF800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic        per_img_bit,
    input  logic [15:0] per_img_data,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [15:0] post_img_data,
    output logic        target_valid,
    output logic [9:0]  box_xmin,
    output logic [9:0]  box_xmax,
    output logic [9:0]  box_ymin,
    output logic [9:0]  box_ymax,
    output logic [18:0] hit_count,
    output logic        frame_done
);

    localparam logic [9:0]  X_SAT   = 10'(IMG_HDISP);
    localparam logic [9:0]  Y_SAT   = 10'(IMG_VDISP);
    localparam logic [9:0]  X_INIT  = 10'(IMG_HDISP - 1);
    localparam logic [9:0]  Y_INIT  = 10'(IMG_VDISP - 1);
    localparam logic [18:0] CNT_SAT = 19'h7FFFF;
    localparam logic [18:0] MIN_CNT = 19'(MIN_PIXELS);

    // The delayed sync registers double as the edge-detect history.
    logic        vsync_q, href_q, clken_q;
    logic [15:0] data_q;
    logic [9:0]  x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic        started_q, started_d;
    logic [9:0]  min_x_q, min_x_d, max_x_q, max_x_d;
    logic [9:0]  min_y_q, min_y_d, max_y_q, max_y_d;
    logic [18:0] acc_cnt_q, acc_cnt_d;
    logic        valid_q, valid_d;
    logic [9:0]  bx0_q, bx0_d, bx1_q, bx1_d, by0_q, by0_d, by1_q, by1_d;
    logic [18:0] hit_q, hit_d;
    logic        done_q, done_d;

    logic rise_s, fall_s, hit_s, on_col_s, on_row_s, border_s;

    assign rise_s = per_frame_vsync & ~vsync_q;
    assign fall_s = ~per_frame_href & href_q;
    // Pixels beyond the active window (overlong lines / extra lines) are ignored.
    assign hit_s  = per_frame_clken & per_frame_href & per_img_bit &
                    (x_cnt_q < X_SAT) & (y_cnt_q < Y_SAT);

    // Border test on the current pixel's coordinate against the published box.
    assign on_col_s = ((x_cnt_q == bx0_q) || (x_cnt_q == bx1_q)) &&
                      (y_cnt_q >= by0_q) && (y_cnt_q <= by1_q);
    assign on_row_s = ((y_cnt_q == by0_q) || (y_cnt_q == by1_q)) &&
                      (x_cnt_q >= bx0_q) && (x_cnt_q <= bx1_q);
    assign border_s = valid_q & (on_col_s | on_row_s);

    // Next-state logic for the coordinate counters, accumulators and results.
    always_comb begin
        x_cnt_d   = x_cnt_q;
        y_cnt_d   = y_cnt_q;
        started_d = started_q;
        min_x_d   = min_x_q;
        max_x_d   = max_x_q;
        min_y_d   = min_y_q;
        max_y_d   = max_y_q;
        acc_cnt_d = acc_cnt_q;
        valid_d   = valid_q;
        bx0_d     = bx0_q;
        bx1_d     = bx1_q;
        by0_d     = by0_q;
        by1_d     = by1_q;
        hit_d     = hit_q;
        done_d    = 1'b0;

        if (!per_frame_href) begin
            x_cnt_d = 10'd0;
        end else if (per_frame_clken && (x_cnt_q != X_SAT)) begin
            x_cnt_d = x_cnt_q + 10'd1;
        end else begin
            x_cnt_d = x_cnt_q;
        end

        if (rise_s) begin
            y_cnt_d = 10'd0;
        end else if (fall_s && (y_cnt_q != Y_SAT)) begin
            y_cnt_d = y_cnt_q + 10'd1;
        end else begin
            y_cnt_d = y_cnt_q;
        end

        if (rise_s) begin
            // The very first boundary after reset only arms publishing, since
            // the frame before it was only partially observed.
            if (started_q) begin
                hit_d   = acc_cnt_q;
                valid_d = (acc_cnt_q >= MIN_CNT);
                done_d  = 1'b1;
                if (acc_cnt_q >= MIN_CNT) begin
                    bx0_d = min_x_q;
                    bx1_d = max_x_q;
                    by0_d = min_y_q;
                    by1_d = max_y_q;
                end else begin
                    bx0_d = bx0_q;
                    bx1_d = bx1_q;
                    by0_d = by0_q;
                    by1_d = by1_q;
                end
            end else begin
                started_d = 1'b1;
            end
            // A hit coincident with the boundary is deliberately dropped.
            min_x_d   = X_INIT;
            max_x_d   = 10'd0;
            min_y_d   = Y_INIT;
            max_y_d   = 10'd0;
            acc_cnt_d = 19'd0;
        end else if (hit_s) begin
            min_x_d   = (x_cnt_q < min_x_q) ? x_cnt_q : min_x_q;
            max_x_d   = (x_cnt_q > max_x_q) ? x_cnt_q : max_x_q;
            min_y_d   = (y_cnt_q < min_y_q) ? y_cnt_q : min_y_q;
            max_y_d   = (y_cnt_q > max_y_q) ? y_cnt_q : max_y_q;
            acc_cnt_d = (acc_cnt_q != CNT_SAT) ? (acc_cnt_q + 19'd1) : acc_cnt_q;
        end else begin
            acc_cnt_d = acc_cnt_q;
        end
    end

    // State register for counters, accumulators and published results.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt_q   <= 10'd0;
            y_cnt_q   <= 10'd0;
            started_q <= 1'b0;
            min_x_q   <= X_INIT;
            max_x_q   <= 10'd0;
            min_y_q   <= Y_INIT;
            max_y_q   <= 10'd0;
            acc_cnt_q <= 19'd0;
            valid_q   <= 1'b0;
            bx0_q     <= 10'd0;
            bx1_q     <= 10'd0;
            by0_q     <= 10'd0;
            by1_q     <= 10'd0;
            hit_q     <= 19'd0;
            done_q    <= 1'b0;
        end else begin
            x_cnt_q   <= x_cnt_d;
            y_cnt_q   <= y_cnt_d;
            started_q <= started_d;
            min_x_q   <= min_x_d;
            max_x_q   <= max_x_d;
            min_y_q   <= min_y_d;
            max_y_q   <= max_y_d;
            acc_cnt_q <= acc_cnt_d;
            valid_q   <= valid_d;
            bx0_q     <= bx0_d;
            bx1_q     <= bx1_d;
            by0_q     <= by0_d;
            by1_q     <= by1_d;
            hit_q     <= hit_d;
            done_q    <= done_d;
        end
    end

    // One-cycle video pipeline with the box overlay.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            clken_q <= 1'b0;
            data_q  <= 16'd0;
        end else begin
            vsync_q <= per_frame_vsync;
            href_q  <= per_frame_href;
            clken_q <= per_frame_clken;
            data_q  <= border_s ? BOX_COLOR : per_img_data;
        end
    end

    assign post_frame_vsync = vsync_q;
    assign post_frame_href  = href_q;
    assign post_frame_clken = clken_q;
    assign post_img_data    = data_q;
    assign target_valid     = valid_q;
    assign box_xmin         = bx0_q;
    assign box_xmax         = bx1_q;
    assign box_ymin         = by0_q;
    assign box_ymax         = by1_q;
    assign hit_count        = hit_q;
    assign frame_done       = done_q;

endmodule

// File: tb/tb_target_bbox_tracker.sv
// Testbench for target_bbox_tracker. Two instances share one stimulus stream:
// dut_a uses MIN_PIXELS = 64, dut_b uses MIN_PIXELS = 1. A frame-level
// reference model tracks pixel coordinates, hit sets and published results.
module tb_target_bbox_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, vs, hr, ck, bt;
    logic [15:0] dat;

    logic        pv_a, ph_a, pc_a, tv_a, fd_a;
    logic [15:0] pd_a;
    logic [9:0]  x0_a, x1_a, y0_a, y1_a;
    logic [18:0] hc_a;
    logic        pv_b, ph_b, pc_b, tv_b, fd_b;
    logic [15:0] pd_b;
    logic [9:0]  x0_b, x1_b, y0_b, y1_b;
    logic [18:0] hc_b;

    target_bbox_tracker #(.MIN_PIXELS(64)) dut_a (
        .clk(clk), .rst(rst), .per_frame_vsync(vs), .per_frame_href(hr),
        .per_frame_clken(ck), .per_img_bit(bt), .per_img_data(dat),
        .post_frame_vsync(pv_a), .post_frame_href(ph_a), .post_frame_clken(pc_a),
        .post_img_data(pd_a), .target_valid(tv_a), .box_xmin(x0_a), .box_xmax(x1_a),
        .box_ymin(y0_a), .box_ymax(y1_a), .hit_count(hc_a), .frame_done(fd_a));

    target_bbox_tracker #(.MIN_PIXELS(1)) dut_b (
        .clk(clk), .rst(rst), .per_frame_vsync(vs), .per_frame_href(hr),
        .per_frame_clken(ck), .per_img_bit(bt), .per_img_data(dat),
        .post_frame_vsync(pv_b), .post_frame_href(ph_b), .post_frame_clken(pc_b),
        .post_img_data(pd_b), .target_valid(tv_b), .box_xmin(x0_b), .box_xmax(x1_b),
        .box_ymin(y0_b), .box_ymax(y1_b), .hit_count(hc_b), .frame_done(fd_b));

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    int m_x, m_y;            // coordinate of the current pixel within frame
    bit m_pvs, m_phr;        // previous vsync / href
    bit m_started;
    int a_cnt, a_x0, a_x1, a_y0, a_y1;
    int p_valid[2], p_hit[2], p_x0[2], p_x1[2], p_y0[2], p_y1[2], p_done[2];
    int min_px[2] = '{64, 1};

    int fd_cnt, bord_a;
    int g_mode, g_x0, g_x1, g_y0, g_y1, g_dens;

    typedef struct {
        int mode, x0, x1, y0, y1;
        int ev, eh, ex0, ex1, ey0, ey1, eb;
    } vec_t;
    vec_t tbl[6];

    task automatic model_reset();
        m_x = 0; m_y = 0; m_pvs = 0; m_phr = 0; m_started = 0;
        a_cnt = 0; a_x0 = 639; a_x1 = 0; a_y0 = 479; a_y1 = 0;
        for (int i = 0; i < 2; i++) begin
            p_valid[i] = 0; p_hit[i] = 0; p_x0[i] = 0; p_x1[i] = 0;
            p_y0[i] = 0; p_y1[i] = 0; p_done[i] = 0;
        end
    endtask

    function automatic bit mborder(int i, int x, int y);
        return (p_valid[i] != 0) &&
               (((x == p_x0[i] || x == p_x1[i]) && y >= p_y0[i] && y <= p_y1[i]) ||
                ((y == p_y0[i] || y == p_y1[i]) && x >= p_x0[i] && x <= p_x1[i]));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model, compare every output one edge later.
    task automatic step(input bit v, input bit h, input bit c, input bit b);
        logic [15:0] d;
        int ed[2];
        bit rise, fall;
        d = 16'($urandom);
        if (d == 16'hF800) d = 16'h0001;
        vs = v; hr = h; ck = c; bt = b; dat = d;
        if (rst) begin
            model_reset();
            ed[0] = 0; ed[1] = 0;
        end else begin
            rise = v && !m_pvs;
            fall = !h && m_phr;
            for (int i = 0; i < 2; i++) begin
                ed[i] = mborder(i, m_x, m_y) ? 32'hF800 : int'(d);
                p_done[i] = 0;
            end
            if (rise) begin
                for (int i = 0; i < 2; i++) begin
                    if (m_started) begin
                        p_hit[i] = a_cnt;
                        p_valid[i] = (a_cnt >= min_px[i]);
                        p_done[i] = 1;
                        if (a_cnt >= min_px[i]) begin
                            p_x0[i] = a_x0; p_x1[i] = a_x1; p_y0[i] = a_y0; p_y1[i] = a_y1;
                        end
                    end
                end
                m_started = 1;
                a_cnt = 0; a_x0 = 639; a_x1 = 0; a_y0 = 479; a_y1 = 0;
            end else if (h && c && b && m_x < 640 && m_y < 480) begin
                if (a_cnt < 524287) a_cnt++;
                if (m_x < a_x0) a_x0 = m_x;
                if (m_x > a_x1) a_x1 = m_x;
                if (m_y < a_y0) a_y0 = m_y;
                if (m_y > a_y1) a_y1 = m_y;
            end
            if (!h) m_x = 0;
            else if (c && m_x < 640) m_x++;
            if (rise) m_y = 0;
            else if (fall && m_y < 480) m_y++;
            m_pvs = v; m_phr = h;
        end
        @(posedge clk);
        #1;
        chk("a_post_vsync", pv_a, rst ? 0 : v);
        chk("a_post_href",  ph_a, rst ? 0 : h);
        chk("a_post_clken", pc_a, rst ? 0 : c);
        chk("b_post_vsync", pv_b, rst ? 0 : v);
        if (rst || c) begin
            chk("a_post_data", pd_a, ed[0]);
            chk("b_post_data", pd_b, ed[1]);
        end
        chk("a_frame_done", fd_a, p_done[0]);
        chk("a_valid", tv_a, p_valid[0]);
        chk("a_hit_count", hc_a, p_hit[0]);
        chk("a_xmin", x0_a, p_x0[0]); chk("a_xmax", x1_a, p_x1[0]);
        chk("a_ymin", y0_a, p_y0[0]); chk("a_ymax", y1_a, p_y1[0]);
        chk("b_frame_done", fd_b, p_done[1]);
        chk("b_valid", tv_b, p_valid[1]);
        chk("b_hit_count", hc_b, p_hit[1]);
        chk("b_xmin", x0_b, p_x0[1]); chk("b_xmax", x1_b, p_x1[1]);
        chk("b_ymin", y0_b, p_y0[1]); chk("b_ymax", y1_b, p_y1[1]);
        if (fd_a) fd_cnt++;
        if (!rst && c && h && pd_a == 16'hF800) bord_a++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        rst = 1'b0;
    endtask

    task automatic vsync_pulse();
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
    endtask

    function automatic bit hitf(int x, int y);
        case (g_mode)
            1:       return x >= g_x0 && x <= g_x1 && y >= g_y0 && y <= g_y1;
            2:       return y < 63 && x == (y * 37) % 50;
            3:       return $urandom_range(99, 0) < g_dens;
            4:       return (y == 200 && x == 640) || (y == 479 && x == 639);
            default: return 1'b0;
        endcase
    endfunction

    task automatic line(input int len, input int ly);
        int px;
        bit c, b;
        px = 0;
        while (px < len) begin
            c = ($urandom_range(3, 0) != 0);
            b = c ? hitf(px, ly) : 1'($urandom);
            step(0, 1, c, b);
            if (c) px++;
        end
        step(0, 0, 1'($urandom), 1'($urandom));
        step(0, 0, 1'($urandom), 1'($urandom));
    endtask

    // Lines not touching the region of interest are kept short to save cycles.
    task automatic frame_body(input int mode, input int rst_line);
        int nl, len;
        g_mode = mode;
        case (mode)
            1:       nl = g_y1 + 2;
            2:       nl = 63;
            3:       nl = 12;
            4:       nl = 480;
            default: nl = (rst_line >= 0) ? 250 : 8;
        endcase
        for (int ly = 0; ly < nl; ly++) begin
            case (mode)
                1:       len = (ly >= g_y0 && ly <= g_y1) ? g_x1 + 3 : 3;
                2:       len = 50;
                3:       len = 24;
                4:       len = (ly == 200) ? 641 : ((ly == 479) ? 640 : 2);
                default: len = 8;
            endcase
            if (ly == rst_line) do_reset(3);
            line(len, ly);
        end
    endtask

    task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
        g_x0 = x0; g_x1 = x1; g_y0 = y0; g_y1 = y1;
    endtask

    initial begin
        // mode, rect, expected publish after the frame, border pixels drawn during it
        tbl[0] = '{1, 100, 149, 200, 229, 1, 1500, 100, 149, 200, 229, 0};
        tbl[1] = '{1, 100, 149, 200, 229, 1, 1500, 100, 149, 200, 229, 2*50 + 2*(30-2)};
        tbl[2] = '{2, 0, 0, 0, 0,         0, 63,   100, 149, 200, 229, 0};
        tbl[3] = '{1, 5, 12, 3, 10,       1, 64,   5, 12, 3, 10,       0};
        tbl[4] = '{1, 20, 20, 7, 7,       0, 1,    5, 12, 3, 10,       2};
        tbl[5] = '{1, 0, 63, 0, 0,        1, 64,   0, 63, 0, 0,        0};

        vs = 0; hr = 0; ck = 0; bt = 0; dat = 16'd0;
        model_reset();
        do_reset(3);

        // Two empty frames: first boundary arms, second publishes zero.
        fd_cnt = 0;
        vsync_pulse();
        chk("first_vsync_no_done", fd_cnt, 0);
        frame_body(0, -1);
        fd_cnt = 0;
        vsync_pulse();
        chk("second_vsync_done", fd_cnt, 1);
        chk("empty_hit_count", hc_a, 0);
        chk("empty_valid", tv_a, 0);

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            set_rect(tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1);
            bord_a = 0;
            frame_body(tbl[i].mode, -1);
            chk($sformatf("tbl%0d_border_px", i), bord_a, tbl[i].eb);
            fd_cnt = 0;
            vsync_pulse();
            chk($sformatf("tbl%0d_done", i), fd_cnt, 1);
            chk($sformatf("tbl%0d_valid", i), tv_a, tbl[i].ev);
            chk($sformatf("tbl%0d_hit", i), hc_a, tbl[i].eh);
            chk($sformatf("tbl%0d_xmin", i), x0_a, tbl[i].ex0);
            chk($sformatf("tbl%0d_xmax", i), x1_a, tbl[i].ex1);
            chk($sformatf("tbl%0d_ymin", i), y0_a, tbl[i].ey0);
            chk($sformatf("tbl%0d_ymax", i), y1_a, tbl[i].ey1);
        end

        // Corner hit at (639,479) plus an ignored hit at x = 640.
        frame_body(4, -1);
        vsync_pulse();
        chk("corner_a_hit", hc_a, 1);
        chk("corner_a_valid", tv_a, 0);
        chk("corner_a_xmax_held", x1_a, 63);
        chk("corner_b_hit", hc_b, 1);
        chk("corner_b_valid", tv_b, 1);
        chk("corner_b_xmin", x0_b, 639);
        chk("corner_b_xmax", x1_b, 639);
        chk("corner_b_ymin", y0_b, 479);
        chk("corner_b_ymax", y1_b, 479);

        // Moving pixel coincident with the vsync rise is dropped.
        step(1, 1, 1, 1); step(1, 0, 0, 0);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        set_rect(5, 12, 3, 10);
        frame_body(1, -1);
        vsync_pulse();
        chk("coincident_hit", hc_a, 64);
        chk("coincident_valid", tv_a, 1);

        // Reset mid-frame at line 240, then two frames with the big rectangle.
        frame_body(0, 240);
        chk("after_reset_valid", tv_a, 0);
        fd_cnt = 0;
        vsync_pulse();
        chk("post_reset_no_done", fd_cnt, 0);
        set_rect(100, 149, 200, 229);
        frame_body(1, -1);
        fd_cnt = 0;
        vsync_pulse();
        chk("post_reset_done", fd_cnt, 1);
        chk("post_reset_hit", hc_a, 1500);
        chk("post_reset_xmin", x0_a, 100);
        chk("post_reset_ymax", y1_a, 229);

        // Random-density frames checked by the model.
        repeat (6) begin
            g_dens = $urandom_range(60, 1);
            frame_body(3, -1);
            vsync_pulse();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
